// File: rtl/maxmin_stim.sv
// Stimulus source and result checker for the max/min tracker: emits LFSR bursts,
// tracks the expected max/min of each burst, and tallies tracker responses.
module maxmin_stim #(
  parameter int DATA_W  = 8,
  parameter int SEQ_LEN = 15,
  parameter int GAP     = 2,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [15:0]       seed,
  input  logic [7:0]        num_seq,
  output logic [DATA_W-1:0] in_num,
  output logic              in_valid,
  input  logic              out_valid,
  input  logic [DATA_W-1:0] out_max,
  input  logic [DATA_W-1:0] out_min,
  output logic              busy,
  output logic              done,
  output logic [7:0]        pass_cnt,
  output logic [7:0]        fail_cnt,
  output logic              err
);

  // state | meaning
  // IDLE  | waiting for start, busy=0
  // SEND  | driving SEQ_LEN consecutive beats
  // WAIT  | waiting up to TIMEOUT cycles for the tracker result
  // GAP   | GAP idle cycles before the next burst
  // DONE  | one-cycle done pulse, then back to IDLE
  typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT, S_GAP, S_DONE} state_t;

  localparam int BW = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = $clog2(GAP + 1);
  localparam logic [15:0] SEED_DEF = 16'hACE1;

  state_t            state;
  logic [15:0]       lfsr;
  logic [15:0]       lfsr_nxt;
  logic [15:0]       seed_eff;
  logic [DATA_W-1:0] beat_val;
  logic [DATA_W-1:0] exp_max;
  logic [DATA_W-1:0] exp_min;
  logic [BW-1:0]     beat_cnt;
  logic [TW-1:0]     timer;
  logic [GW-1:0]     gap_cnt;
  logic [7:0]        burst_cnt;
  logic [7:0]        burst_inc;
  logic [7:0]        num_seq_r;
  logic              match;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Right-shifting Fibonacci form; taps 16,14,13,11 map to bits 0,2,3,5.
  assign lfsr_nxt  = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
  assign seed_eff  = (seed == 16'd0) ? SEED_DEF : seed;
  assign beat_val  = lfsr_nxt[DATA_W-1:0];
  assign burst_inc = burst_cnt + 8'd1;
  assign match     = (out_max == exp_max) && (out_min == exp_min);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      lfsr      <= SEED_DEF;
      exp_max   <= '0;
      exp_min   <= '0;
      beat_cnt  <= '0;
      timer     <= '0;
      gap_cnt   <= '0;
      burst_cnt <= '0;
      num_seq_r <= '0;
      in_num    <= '0;
      in_valid  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass_cnt  <= '0;
      fail_cnt  <= '0;
      err       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            lfsr      <= seed_eff;
            num_seq_r <= num_seq;
            pass_cnt  <= '0;
            fail_cnt  <= '0;
            err       <= 1'b0;
            burst_cnt <= '0;
            busy      <= 1'b1;
            if (num_seq == 8'd0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state    <= S_SEND;
              in_valid <= 1'b1;
              in_num   <= seed_eff[DATA_W-1:0];
              exp_max  <= seed_eff[DATA_W-1:0];
              exp_min  <= seed_eff[DATA_W-1:0];
              beat_cnt <= '0;
            end
          end else if (out_valid) begin
            err <= 1'b1;
          end
        end

        S_SEND: begin
          if (out_valid) err <= 1'b1;
          if (beat_cnt == BW'(SEQ_LEN - 1)) begin
            in_valid <= 1'b0;
            in_num   <= '0;
            timer    <= '0;
            state    <= S_WAIT;
          end else begin
            lfsr     <= lfsr_nxt;
            in_num   <= beat_val;
            exp_max  <= (beat_val > exp_max) ? beat_val : exp_max;
            exp_min  <= (beat_val < exp_min) ? beat_val : exp_min;
            beat_cnt <= beat_cnt + BW'(1);
          end
        end

        S_WAIT: begin
          if (out_valid) begin
            if (match) begin
              pass_cnt <= sat_inc(pass_cnt);
            end else begin
              fail_cnt <= sat_inc(fail_cnt);
              err      <= 1'b1;
            end
            burst_cnt <= burst_inc;
            if (burst_inc == num_seq_r) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state   <= S_GAP;
              gap_cnt <= '0;
            end
          end else if (timer == TW'(TIMEOUT - 1)) begin
            // A silent tracker aborts the remaining bursts.
            fail_cnt <= sat_inc(fail_cnt);
            err      <= 1'b1;
            state    <= S_DONE;
            done     <= 1'b1;
          end else begin
            timer <= timer + TW'(1);
          end
        end

        S_GAP: begin
          if (out_valid) err <= 1'b1;
          if (gap_cnt == GW'(GAP - 1)) begin
            lfsr     <= lfsr_nxt;
            in_num   <= beat_val;
            in_valid <= 1'b1;
            exp_max  <= beat_val;
            exp_min  <= beat_val;
            beat_cnt <= '0;
            state    <= S_SEND;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end

        S_DONE: begin
          if (out_valid) err <= 1'b1;
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_maxmin_stim.sv
// Bench for maxmin_stim: behavioural tracker responder plus a scoreboard of
// expected beats and expected end-of-run tallies.
module tb_maxmin_stim;
  localparam int DW = 8;
  localparam int SL = 15;
  localparam int GP = 2;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [15:0]   seed = 16'd0;
  logic [7:0]    num_seq = 8'd0;
  logic [DW-1:0] in_num;
  logic          in_valid;
  logic          out_valid = 1'b0;
  logic [DW-1:0] out_max = '0;
  logic [DW-1:0] out_min = '0;
  logic          busy;
  logic          done;
  logic [7:0]    pass_cnt;
  logic [7:0]    fail_cnt;
  logic          err;

  maxmin_stim #(.DATA_W(DW), .SEQ_LEN(SL), .GAP(GP), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .seed(seed), .num_seq(num_seq),
    .in_num(in_num), .in_valid(in_valid), .out_valid(out_valid),
    .out_max(out_max), .out_min(out_min), .busy(busy), .done(done),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pass_e;
    int fail_e;
    bit err_e;
    int lat;
  } res_t;

  int            checks = 0;
  int            errors = 0;
  res_t          res_q[$];
  logic [DW-1:0] beat_q[$];
  int            mode = 0;     // 0 correct, 1 corrupt burst 2, 2 silent, 3 extra pulse in gap
  int            bidx = 0;
  int            done_seen = 0;
  bit            first_chk = 0;
  bit            run_first = 0;
  logic [DW-1:0] first_exp = '0;

  // responder / monitor state
  bit            prev_iv = 0;
  bit            prev_done = 0;
  bit            resp_now = 0;
  bit            extra_pend = 0;
  bit            gap_track = 0;
  int            gap_cnt = 0;
  int            since = 0;
  logic [DW-1:0] amax = '0;
  logic [DW-1:0] amin = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] m_step(input logic [15:0] s);
    logic [15:0] t;
    t = s ^ (s >> 2) ^ (s >> 3) ^ (s >> 5);
    return {t[0], s[15:1]};
  endfunction

  task automatic push_run(input logic [15:0] sd, input int nbursts);
    logic [15:0] s;
    s = (sd == 16'd0) ? 16'hACE1 : sd;
    for (int b = 0; b < nbursts; b++)
      for (int i = 0; i < SL; i++) begin
        beat_q.push_back(s[DW-1:0]);
        s = m_step(s);
      end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_iv = 0; prev_done = 0; resp_now = 0; extra_pend = 0;
      gap_track = 0; since = 0; out_valid = 1'b0; out_max = '0; out_min = '0;
    end else begin
      // monitor
      if (in_valid) begin
        if (beat_q.size() == 0) check("unexpected_beat", 32'(in_num), 32'hFFFF_FFFF);
        else check("in_num", 32'(in_num), 32'(beat_q.pop_front()));
        if (run_first && first_chk) check("first_beat", 32'(in_num), 32'(first_exp));
        run_first = 0;
        since = 0;
      end else begin
        check("idle_in_num", 32'(in_num), 32'd0);
        since++;
      end
      if (gap_track) begin
        if (in_valid) begin
          check("gap_len", gap_cnt, GP);
          gap_track = 0;
        end else gap_cnt++;
      end
      if (resp_now) begin
        gap_track = 1;
        gap_cnt = 1;
      end
      if (prev_done) begin
        check("done_width", 32'(done), 32'd0);
        check("busy_after_done", 32'(busy), 32'd0);
      end
      if (done) begin
        res_t r;
        gap_track = 0;
        if (res_q.size() == 0) check("unexpected_done", 32'd1, 32'd0);
        else begin
          r = res_q.pop_front();
          check("pass_cnt", 32'(pass_cnt), r.pass_e);
          check("fail_cnt", 32'(fail_cnt), r.fail_e);
          check("err", 32'(err), 32'(r.err_e));
          check("beats_left", beat_q.size(), 0);
          if (r.lat >= 0) check("done_latency", since, r.lat);
        end
        done_seen++;
      end
      prev_done = done;

      // responder: latency-1 tracker model
      if (in_valid) begin
        if (!prev_iv) begin amax = in_num; amin = in_num; end
        else begin
          if (in_num > amax) amax = in_num;
          if (in_num < amin) amin = in_num;
        end
      end
      resp_now = 0;
      if (extra_pend) begin
        out_valid = 1'b1; out_max = '0; out_min = '0;
        extra_pend = 0;
      end else if (prev_iv && !in_valid && mode != 2) begin
        out_valid = 1'b1;
        out_max = (mode == 1 && bidx == 1) ? amax + DW'(1) : amax;
        out_min = amin;
        resp_now = 1;
        if (mode == 3 && bidx == 0) extra_pend = 1;
        bidx++;
      end else begin
        out_valid = 1'b0; out_max = '0; out_min = '0;
      end
      prev_iv = in_valid;
    end
  end

  task automatic run(input logic [15:0] sd, input logic [7:0] ns, input int m, input int nsent,
                     input int pe, input int fe, input bit ee, input int lat,
                     input bit fchk, input logic [DW-1:0] fval, input bit poke);
    res_t r;
    int   target;
    int   n;
    mode = m;
    bidx = 0;
    push_run(sd, nsent);
    r.pass_e = pe; r.fail_e = fe; r.err_e = ee; r.lat = lat;
    res_q.push_back(r);
    first_chk = fchk;
    first_exp = fval;
    target = done_seen + 1;
    @(negedge clk);
    start = 1'b1; seed = sd; num_seq = ns; run_first = 1;
    @(negedge clk);
    start = 1'b0;
    if (ns == 8'd0) begin
      #1 check("done_after_start", 32'(done), 32'd1);
    end
    if (poke) begin
      // start while busy must be ignored
      repeat (5) @(negedge clk);
      start = 1'b1; seed = 16'hFFFF; num_seq = 8'd9;
      @(negedge clk);
      start = 1'b0;
    end
    n = 0;
    while (done_seen < target && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (done_seen < target) begin
      checks++; errors++;
      $display("FAIL run_timeout got no done expected done within 500 cycles");
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_in_num", 32'(in_num), 32'd0);
    check("rst_in_valid", 32'(in_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass_cnt), 32'd0);
    check("rst_fail", 32'(fail_cnt), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run(16'h0000, 8'd1, 0, 1, 1, 0, 1'b0, -1, 1'b1, 8'hE1, 1'b0);
    run(16'h0001, 8'd3, 0, 3, 3, 0, 1'b0, -1, 1'b1, 8'h01, 1'b1);
    run(16'h1234, 8'd3, 1, 3, 2, 1, 1'b1, -1, 1'b1, 8'h34, 1'b0);
    run(16'hBEEF, 8'd3, 2, 1, 0, 1, 1'b1, TO + 1, 1'b1, 8'hEF, 1'b0);
    run(16'h0042, 8'd0, 0, 0, 0, 0, 1'b0, -1, 1'b0, 8'h00, 1'b0);
    run(16'h00C3, 8'd2, 3, 2, 2, 0, 1'b1, -1, 1'b1, 8'hC3, 1'b0);

    // reset in the middle of burst 1, while beat 7 is on the bus
    mode = 0; bidx = 0;
    push_run(16'h0055, 2);
    first_chk = 0;
    @(negedge clk);
    start = 1'b1; seed = 16'h0055; num_seq = 8'd2;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    check("pre_reset_valid", 32'(in_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_in_valid", 32'(in_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_pass", 32'(pass_cnt), 32'd0);
    check("mid_rst_fail", 32'(fail_cnt), 32'd0);
    check("mid_rst_in_num", 32'(in_num), 32'd0);
    beat_q.delete();
    res_q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_busy", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no finish expected finish before 200000ns");
    $fatal(1, "watchdog");
  end

endmodule
